pc_sequencer: RTL

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer_pkg.sv | 37 +++
 rtl/pc_sequencer_next_calc.sv | 31 +++
 rtl/pc_sequencer.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared defines for the PC sequencer: next-PC select codes, branch funct3
// codes, FSM state encoding, the NOP word and default vectors.
package pc_sequencer_pkg;

    // Next-PC select codes driven by the decoder; code 2'b11 is undefined
    // and falls back to sequential fetch.
    localparam logic [1:0] PC_NEXT_INST     = 2'b00;
    localparam logic [1:0] PC_BRANCH_OFFSET = 2'b01;
    localparam logic [1:0] PC_ALU_RESULT    = 2'b10;

    // Branch comparison funct3 codes shared with the decoder.
    localparam logic [2:0] FUNCT3_BEQ  = 3'b000;
    localparam logic [2:0] FUNCT3_BNE  = 3'b001;
    localparam logic [2:0] FUNCT3_BLT  = 3'b100;
    localparam logic [2:0] FUNCT3_BGE  = 3'b101;
    localparam logic [2:0] FUNCT3_BLTU = 3'b110;
    localparam logic [2:0] FUNCT3_BGEU = 3'b111;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0100;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'b00,
        ST_FETCH = 2'b01,
        ST_EXEC  = 2'b10,
        ST_TRAP  = 2'b11
    } seq_state_e;

    // Instruction addresses must be word aligned.
    function automatic logic is_aligned(input logic [1:0] addr_lsbs);
        return addr_lsbs == 2'b00;
    endfunction

endpackage

// File: rtl/pc_sequencer_next_calc.sv
// Combinational next-PC selection (sequential, PC-relative branch, absolute
// jump) with word-misalignment detection. All arithmetic wraps modulo 2^32.
module pc_next_calc
    import pc_sequencer_pkg::*;
(
    input  logic [31:0] pc_i,
    input  logic [1:0]  pc_sel_i,
    input  logic [31:0] branch_offset_i,
    input  logic [31:0] alu_result_i,
    output logic [31:0] next_pc_o,
    output logic        misaligned_o
);

    // Select the candidate next PC; jump targets always have bit 0 cleared.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path through the case leaves it unassigned and infers a latch.
        next_pc_o = pc_i + 32'd4;
        case (pc_sel_i)
            PC_BRANCH_OFFSET: next_pc_o = pc_i + branch_offset_i;
            PC_ALU_RESULT:    next_pc_o = alu_result_i & ~32'd1;
            default:          next_pc_o = pc_i + 32'd4;
        endcase
    end

    // Flag any target that is not word aligned.
    always_comb begin
        misaligned_o = !is_aligned(next_pc_o[1:0]);
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: boots, fetches one instruction word at a time,
// holds it for execution, retires (possibly after a data-memory stall) and
// redirects to the trap vector on a misaligned control transfer.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter logic [31:0] TRAP_VECTOR  = DEFAULT_TRAP_VECTOR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  pc_sel,
    input  logic [31:0] branch_offset,
    input  logic [31:0] alu_result,
    input  logic        exec_done,
    input  logic        mem_stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic        misalign_trap
);

    seq_state_e  state_q, state_d;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic        imem_req_q, imem_req_d;
    logic        instr_valid_q, instr_valid_d;
    logic        trap_q, trap_d;

    // Retirement captured while the data memory was stalled.
    logic        pend_q;
    logic [1:0]  pend_sel_q;
    logic [31:0] pend_off_q;
    logic [31:0] pend_alu_q;

    logic [1:0]  calc_sel;
    logic [31:0] calc_off;
    logic [31:0] calc_alu;
    logic [31:0] next_pc;
    logic        next_misaligned;
    logic        in_exec;
    logic        retire;

    // A pending retirement uses the operands captured at its exec_done cycle.
    always_comb begin
        calc_sel = pend_q ? pend_sel_q : pc_sel;
        calc_off = pend_q ? pend_off_q : branch_offset;
        calc_alu = pend_q ? pend_alu_q : alu_result;
    end

    pc_next_calc u_next_calc (
        .pc_i            (pc_q),
        .pc_sel_i        (calc_sel),
        .branch_offset_i (calc_off),
        .alu_result_i    (calc_alu),
        .next_pc_o       (next_pc),
        .misaligned_o    (next_misaligned)
    );

    // Retire when the instruction is done (now or earlier) and memory is free.
    always_comb begin
        in_exec = (state_q == ST_EXEC);
        retire  = in_exec && !mem_stall && (exec_done || pend_q);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!rst_n) state_q <= ST_BOOT;
        else        state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BOOT:  state_d = ST_FETCH;
            ST_FETCH: if (imem_ack) state_d = ST_EXEC;
            ST_EXEC:  if (retire) state_d = next_misaligned ? ST_TRAP : ST_FETCH;
            ST_TRAP:  state_d = ST_FETCH;
            default:  state_d = ST_BOOT;
        endcase
    end

    // Output decode of the upcoming state, registered below so outputs are flops.
    always_comb begin
        imem_req_d    = (state_d == ST_FETCH);
        instr_valid_d = (state_d == ST_EXEC);
        trap_d        = (state_d == ST_TRAP);
    end

    // Registered control outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b0;
            trap_q        <= 1'b0;
        end else begin
            imem_req_q    <= imem_req_d;
            instr_valid_q <= instr_valid_d;
            trap_q        <= trap_d;
        end
    end

    // PC and instruction latch: update on retire, trap redirect and fetch ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_VECTOR;
            instr_q <= NOP_INSTR;
        end else begin
            if (retire && !next_misaligned) pc_q <= next_pc;
            else if (state_q == ST_TRAP)    pc_q <= TRAP_VECTOR;
            if (state_q == ST_FETCH && imem_ack) instr_q <= imem_rdata;
        end
    end

    // Capture a stalled retirement; clear it once it completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q     <= 1'b0;
            pend_sel_q <= PC_NEXT_INST;
            pend_off_q <= '0;
            pend_alu_q <= '0;
        end else if (retire) begin
            pend_q <= 1'b0;
        end else if (in_exec && exec_done && mem_stall && !pend_q) begin
            pend_q     <= 1'b1;
            pend_sel_q <= pc_sel;
            pend_off_q <= branch_offset;
            pend_alu_q <= alu_result;
        end
    end

    assign imem_req      = imem_req_q;
    assign imem_addr     = pc_q;
    assign pc            = pc_q;
    assign instr         = instr_q;
    assign instr_valid   = instr_valid_q;
    assign misalign_trap = trap_q;

endmodule
